// File: rtl/fma_arbiter.sv
// Shares one fixed-latency FMA pipeline among NREQ requesters and returns each result to its owner.
// Define FMA_ARBITER_RR_EN for round-robin arbitration; otherwise lowest index wins.
module fma_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LAT     = 5,
    parameter int unsigned MAX_OUT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [32*NREQ-1:0]      req_a,
    input  logic [32*NREQ-1:0]      req_b,
    input  logic [32*NREQ-1:0]      req_c,
    input  logic                    hold,
    output logic [31:0]             fma_a,
    output logic [31:0]             fma_b,
    output logic [31:0]             fma_c,
    input  logic [31:0]             fma_result,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [31:0]             rsp_data,
    output logic                    idle
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);

    logic [CW-1:0]   r_out [NREQ];
    logic [LAT-1:0]  r_tag_vld;
    logic [IDW-1:0]  r_tag_id [LAT];

    logic [NREQ-1:0] w_elig;
    logic            w_gnt;
    logic [IDW-1:0]  w_gnt_id;

    assign rsp_valid = r_tag_vld[LAT-1];
    assign rsp_id    = r_tag_id[LAT-1];
    assign rsp_data  = rsp_valid ? fma_result : 32'h0;
    assign idle      = ~(|r_tag_vld) && !w_gnt;

    // A slot freed by this cycle's response can be refilled in the same cycle.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            w_elig[i] = req_valid[i] && !hold && !rst &&
                        ((r_out[i] < MAX_OUT_C) || (rsp_valid && rsp_id == IDW'(i)));
        end
    end

`ifdef FMA_ARBITER_RR_EN
    logic [IDW-1:0] r_ptr;

    always_comb begin
        int idx;
        idx      = 0;
        w_gnt    = 1'b0;
        w_gnt_id = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
            if (!w_gnt && w_elig[IDW'(idx)]) begin
                w_gnt    = 1'b1;
                w_gnt_id = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_gnt) begin
            r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
        end
    end
`else
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_id = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_gnt    = 1'b1;
                w_gnt_id = IDW'(i);
            end
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        fma_a     = 32'h0;
        fma_b     = 32'h0;
        fma_c     = 32'h0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_gnt && w_gnt_id == IDW'(i)) begin
                req_ready[i] = 1'b1;
                fma_a        = req_a[32*i +: 32];
                fma_b        = req_b[32*i +: 32];
                fma_c        = req_c[32*i +: 32];
            end
        end
    end

    // Tag pipeline mirrors the FMA pipeline depth; it never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int j = 0; j < int'(LAT); j++) begin
                r_tag_id[j] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_gnt;
            r_tag_id[0]  <= w_gnt_id;
            for (int j = 1; j < int'(LAT); j++) begin
                r_tag_vld[j] <= r_tag_vld[j-1];
                r_tag_id[j]  <= r_tag_id[j-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                r_out[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_ready[i] && !(rsp_valid && rsp_id == IDW'(i))) begin
                    if (r_out[i] != MAX_OUT_C) begin
                        r_out[i] <= r_out[i] + 1'b1;
                    end
                end else if (!req_ready[i] && rsp_valid && rsp_id == IDW'(i)) begin
                    if (r_out[i] != '0) begin
                        r_out[i] <= r_out[i] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fma_arbiter.sv
// Directed bench for fma_arbiter; define FMA_ARBITER_RR_EN for the round-robin expectations.
// A behavioural stand-in for the FMA pipeline delays a per-operand signature by LAT cycles.
`timescale 1ns/1ps
module tb_fma_arbiter;
    localparam int NREQ    = 4;
    localparam int LAT     = 5;
    localparam int MAX_OUT = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [32*NREQ-1:0] req_c;
    logic               hold;
    logic [31:0]        fma_a;
    logic [31:0]        fma_b;
    logic [31:0]        fma_c;
    logic [31:0]        fma_result;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [31:0]        rsp_data;
    logic               idle;
    logic [31:0]        pipe [LAT];

    int errors = 0;
    int checks = 0;

    fma_arbiter #(.NREQ(NREQ), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .hold       (hold),
        .fma_a      (fma_a),
        .fma_b      (fma_b),
        .fma_c      (fma_c),
        .fma_result (fma_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fake_fma(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h3F800000) return 32'h40400000;
        return a ^ b ^ c;
    endfunction

    function automatic logic [31:0] op_a(input int i);
        return 32'hA000_0000 | 32'(i);
    endfunction
    function automatic logic [31:0] op_b(input int i);
        return 32'h0B00_0000 | (32'(i) << 8);
    endfunction
    function automatic logic [31:0] op_c(input int i);
        return 32'h00C0_0000 | (32'(i) << 16);
    endfunction
    function automatic logic [31:0] exp_data(input int i);
        return fake_fma(op_a(i), op_b(i), op_c(i));
    endfunction

    always @(posedge clk) begin
        pipe[0] <= fake_fma(fma_a, fma_b, fma_c);
        for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign fma_result = pipe[LAT-1];

    task automatic set_default_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = op_a(i);
            req_b[32*i +: 32] = op_b(i);
            req_c[32*i +: 32] = op_c(i);
        end
    endtask

    // Leaves the bench at a falling edge, in the first cycle after reset release.
    task automatic do_reset();
        req_valid = '0;
        hold      = 1'b0;
        set_default_ops();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        hold      = 1'b0;
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic test_reset();
        req_valid = '1;
        hold      = 1'b0;
        set_default_ops();
        rst = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || idle !== 1'b1
                || fma_a !== 32'h0) begin
                errors++;
                $display("FAIL reset_state: ready=%b rsp_valid=%b rsp_id=%0d idle=%b fma_a=%h, want 0000 0 0 1 0",
                         req_ready, rsp_valid, rsp_id, idle, fma_a);
            end
        end
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_single_op();
        do_reset();
        req_a[31:0] = 32'h3F800000;
        req_b[31:0] = 32'h40000000;
        req_c[31:0] = 32'h3F800000;
        req_valid   = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || fma_a !== 32'h3F800000 || idle !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: ready=%b fma_a=%h idle=%b, want 0001 3f800000 0",
                     req_ready, fma_a, idle);
        end
        @(negedge clk);
        req_valid = '0;
        for (int c = 1; c <= LAT + 1; c++) begin
            #1;
            checks++;
            if (c == LAT) begin
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h40400000) begin
                    errors++;
                    $display("FAIL single_rsp: valid=%b id=%0d data=%h, want 1 0 40400000",
                             rsp_valid, rsp_id, rsp_data);
                end
            end else if (rsp_valid !== 1'b0 || idle !== (c == LAT + 1)) begin
                errors++;
                $display("FAIL single_quiet cycle %0d: rsp_valid=%b idle=%b", c, rsp_valid, idle);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int exp_g [10];
        do_reset();
`ifdef FMA_ARBITER_RR_EN
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
`else
        exp_g = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
`endif
        for (int k = 0; k < 10; k++) begin
            req_valid = 4'hF;
            #1;
            checks++;
            if (req_ready !== (4'b0001 << exp_g[k]) || fma_a !== op_a(exp_g[k])) begin
                errors++;
                $display("FAIL b2b_grant cycle %0d: ready=%b fma_a=%h, want grant %0d", k,
                         req_ready, fma_a, exp_g[k]);
            end
            if (k >= LAT) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_g[k-LAT])
                    || rsp_data !== exp_data(exp_g[k-LAT])) begin
                    errors++;
                    $display("FAIL b2b_rsp cycle %0d: valid=%b id=%0d data=%h, want 1 %0d %h", k,
                             rsp_valid, rsp_id, rsp_data, exp_g[k-LAT], exp_data(exp_g[k-LAT]));
                end
            end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_max_out();
        logic [7:0] exp_rdy;
        exp_rdy = 8'b1110_0111;  // bit k = expected req_ready[2] in cycle k
        do_reset();
        for (int k = 0; k < 8; k++) begin
            req_valid = 4'b0100;
            #1;
            checks++;
            if (req_ready !== {1'b0, exp_rdy[k], 2'b00}) begin
                errors++;
                $display("FAIL max_out_ready cycle %0d: ready=%b, want %b", k, req_ready,
                         {1'b0, exp_rdy[k], 2'b00});
            end
            if (k == LAT) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== exp_data(2)) begin
                    errors++;
                    $display("FAIL max_out_rsp: valid=%b id=%0d data=%h, want 1 2 %h",
                             rsp_valid, rsp_id, rsp_data, exp_data(2));
                end
            end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_hold();
        int exp_g [4];
        do_reset();
`ifdef FMA_ARBITER_RR_EN
        exp_g = '{0, 1, 2, 3};
`else
        exp_g = '{0, 0, 0, 1};
`endif
        for (int k = 0; k < 10; k++) begin
            req_valid = 4'hF;
            hold      = (k >= 4);
            #1;
            checks++;
            if (k < 4) begin
                if (req_ready !== (4'b0001 << exp_g[k])) begin
                    errors++;
                    $display("FAIL hold_fill cycle %0d: ready=%b, want grant %0d", k, req_ready,
                             exp_g[k]);
                end
            end else if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL hold_block cycle %0d: ready=%b, want 0000", k, req_ready);
            end
            if (k >= LAT && k < LAT + 4) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_g[k-LAT]) || idle !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_rsp cycle %0d: valid=%b id=%0d idle=%b, want 1 %0d 0", k,
                             rsp_valid, rsp_id, idle, exp_g[k-LAT]);
                end
            end
            if (k == 9) begin
                checks++;
                if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_idle: rsp_valid=%b idle=%b, want 0 1", rsp_valid, idle);
                end
            end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0001;
            #1;
            checks++;
            if (req_ready !== 4'b0001) begin
                errors++;
                $display("FAIL rstmid_accept cycle %0d: ready=%b, want 0001", k, req_ready);
            end
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
        req_valid = 4'b0001;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || idle !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_inreset: ready=%b idle=%b rsp_valid=%b, want 0000 1 0",
                     req_ready, idle, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        for (int k = 0; k < LAT + 1; k++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_discard cycle %0d: rsp_valid=%b idle=%b, want 0 1", k,
                         rsp_valid, idle);
            end
            @(negedge clk);
        end
        // Counters cleared: three fresh acceptances, then the limit applies.
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b0001;
            #1;
            checks++;
            if (req_ready !== ((k < MAX_OUT) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL rstmid_count cycle %0d: ready=%b, want %b", k, req_ready,
                         (k < MAX_OUT) ? 4'b0001 : 4'b0000);
            end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_valid_drop();
        do_reset();
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL drop_ready: ready=%b, want 0010", req_ready);
        end
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || idle !== 1'b1) begin
            errors++;
            $display("FAIL drop_noaccept: ready=%b idle=%b, want 0000 1", req_ready, idle);
        end
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
                errors++;
                $display("FAIL drop_norsp cycle %0d: rsp_valid=%b idle=%b, want 0 1", k,
                         rsp_valid, idle);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        req_valid = '0;
        hold      = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        test_reset();
        test_single_op();
        test_back_to_back();
        test_max_out();
        test_hold();
        test_reset_mid();
        test_valid_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
